// File: rtl/bus_loader.sv
// Boot loader: accepts program words, writes them to SRAM, reads back a checksum, then releases the processor.
// Latency: 2 cycles per word to load, 2 per word to verify, 1 to check; in_ready is high only while waiting for a word.
module bus_loader #(
  parameter int LOAD_LIMIT = 128,
  parameter int WIDTH      = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_dout,
  output logic             bus_w,
  input  logic [WIDTH-1:0] bus_din,
  output logic             proc_run,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE, ACCEPT, WRITE, VADDR, VACC, CHECK, RUN, FAIL
  } state_t;

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(LOAD_LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] index;
  logic [WIDTH-1:0] load_sum;
  logic [WIDTH-1:0] verify_sum;
  logic             last_q;

  // All outputs are registered: each is loaded on the edge that enters the state owning it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      load_sum   <= '0;
      verify_sum <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      bus_addr   <= '0;
      bus_dout   <= '0;
      bus_w      <= 1'b0;
      proc_run   <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, FAIL: begin
          if (start) begin
            count      <= '0;
            index      <= '0;
            load_sum   <= '0;
            verify_sum <= '0;
            error      <= 1'b0;
            proc_run   <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            bus_addr   <= '0;
            bus_dout   <= '0;
            state      <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            last_q   <= in_last;
            in_ready <= 1'b0;
            bus_w    <= 1'b1;
            bus_addr <= count;
            bus_dout <= in_data;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // bus_dout still holds the captured word during this cycle.
          load_sum <= load_sum + bus_dout;
          count    <= count + ONE;
          bus_w    <= 1'b0;
          bus_dout <= '0;
          if (last_q || count == LAST_ADDR) begin
            index    <= '0;
            bus_addr <= '0;
            state    <= VADDR;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        VADDR: begin
          state <= VACC;
        end
        VACC: begin
          verify_sum <= verify_sum + bus_din;
          index      <= index + ONE;
          if (index + ONE < count) begin
            bus_addr <= index + ONE;
            state    <= VADDR;
          end else begin
            bus_addr <= '0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          busy <= 1'b0;
          if (verify_sum == load_sum) begin
            proc_run <= 1'b1;
            state    <= RUN;
          end else begin
            error <= 1'b1;
            state <= FAIL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_loader.md
BUS_LOADER -- requirements
Module: bus_loader

Interface
REQ-001 SHALL have parameter LOAD_LIMIT, default 128: number of SRAM words reachable by the loader (addresses 0..LOAD_LIMIT-1).
REQ-002 SHALL have parameter WIDTH, default 9: bus data and address width.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a load.
REQ-006 SHALL have port in_data, input, WIDTH: program word from the upstream source.
REQ-007 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-008 SHALL have port in_last, input, 1: the current word is the final program word.
REQ-009 SHALL have port in_ready, output, 1: loader accepts a word this cycle.
REQ-010 SHALL have port bus_addr, output, WIDTH: bus address driven by the loader.
REQ-011 SHALL have port bus_dout, output, WIDTH: write data driven by the loader.
REQ-012 SHALL have port bus_w, output, 1: write strobe.
REQ-013 SHALL have port bus_din, input, WIDTH: read data, valid one clock after bus_addr is presented with bus_w=0 (synchronous SRAM, bypass read mode).
REQ-014 SHALL have port proc_run, output, 1: processor run enable; the loader owns the bus while this is 0.
REQ-015 SHALL have port busy, output, 1: load or verify in progress.
REQ-016 SHALL have port error, output, 1: checksum mismatch detected.

Function
REQ-017 SHALL implement states IDLE, ACCEPT, WRITE, VADDR, VACC, CHECK, RUN, FAIL.
REQ-018 IDLE/RUN/FAIL: on start=1, SHALL clear the word count, the load sum, the verify sum and error, then enter ACCEPT next cycle; start SHALL be ignored in all other states.
REQ-019 ACCEPT: in_ready=1; on in_valid&in_ready SHALL capture in_data and in_last and enter WRITE; with in_valid=0 SHALL stay in ACCEPT indefinitely.
REQ-020 in_ready SHALL be 1 only in ACCEPT.
REQ-021 WRITE SHALL last exactly one cycle and drive bus_w=1, bus_addr=count (upper two bits always 0, SRAM region), bus_dout=captured word.
REQ-022 In WRITE, the loader SHALL update load_sum to (load_sum + word) mod 2^WIDTH and increment count.
REQ-023 After WRITE, the loader SHALL go to VADDR when the captured in_last=1 or the write address was LOAD_LIMIT-1; otherwise it SHALL return to ACCEPT.
REQ-024 Address LOAD_LIMIT-1 is the boundary case: no further words are accepted, and the loader SHALL treat the word written there as the last word even when in_last=0.
REQ-025 Verify: the index SHALL start at 0. VADDR drives bus_addr=index with bus_w=0. VACC adds bus_din to verify_sum mod 2^WIDTH and increments index. The loader SHALL go from VACC to VADDR while index+1<count, else to CHECK.
REQ-026 The read latency SHALL be one cycle, so each word takes 2 cycles to verify.
REQ-027 CHECK SHALL last one cycle. When verify_sum==load_sum it SHALL go to RUN; otherwise it SHALL go to FAIL.
REQ-028 RUN: proc_run=1, busy=0, bus_w=0, bus_addr=0, bus_dout=0.
REQ-029 FAIL: error=1 (held until the next start or reset), proc_run=0, busy=0, bus_w=0.
REQ-030 busy SHALL be 1 in ACCEPT, WRITE, VADDR, VACC and CHECK, and 0 otherwise.
REQ-031 bus_w SHALL be 0 in every state except WRITE.
REQ-032 proc_run SHALL be 1 only in RUN, so the loader and the processor never drive the bus in the same cycle.

Reset
REQ-033 On reset assertion, the loader SHALL immediately (asynchronously) enter IDLE with all outputs 0 and count, sums and index cleared; this applies at any point, including mid-load and mid-verify.
REQ-034 After reset release, the loader SHALL remain in IDLE until start; the processor SHALL stay halted (proc_run=0).

Verification
REQ-035 Load words 0x001, 0x002, 0x1FF (last on third) with an SRAM model -> writes at addresses 0, 1, 2; sum 0x002; CHECK passes; proc_run=1 one cycle after CHECK.
REQ-036 Same load, but the model corrupts address 1 to 0x003 -> verify_sum 0x003 != 0x002; error=1, proc_run=0; a new start clears error.
REQ-037 Stream of 130 words, never last -> exactly 128 writes (addresses 0..127); in_ready=0 after the 128th word; verify covers 128 words.
REQ-038 in_valid gapped (valid for 1 cycle, idle for 3 cycles) -> in_ready stays 1 through the gaps; one bus_w pulse per accepted word; no writes during gaps.
REQ-039 Reset asserted in WRITE of the 2nd word -> bus_w drops without waiting for a clock edge; all outputs 0; a subsequent start reloads from address 0.
REQ-040 start pulsed during ACCEPT and during VACC -> no effect: count and sums are unchanged.
